cpt4_comparator: RTL and testbench

// - Registered magnitude comparator: compares operands A and B, drives Y = (A > B)

---
 rtl/cpt4_comparator.sv | 64 ++++++
 tb/tb_cpt4_comparator.sv | 107 ++++++++++
 2 files changed

// File: rtl/cpt4_comparator.sv
// cpt4_comparator: registered WIDTH-bit magnitude compare, 1-cycle latency (clk, rst_n async low, in_valid, A, B -> out_valid, Y=gt, gt, eq, lt); CPT4_CASCADE_EN adds casc_gt/casc_eq/casc_lt slice chaining
module cpt4_comparator #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef CPT4_CASCADE_EN
  input  logic             casc_gt,
  input  logic             casc_eq,
  input  logic             casc_lt,
`endif
  output logic             out_valid,
  output logic             Y,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  localparam bit SX = (SIGNED != 0);
  logic signed [WIDTH:0] a_x, b_x;
  logic local_gt, local_eq, cmp_gt, cmp_eq, cmp_lt;
  logic out_valid_d, gt_d, eq_d, lt_d;
  logic out_valid_q, gt_q, eq_q, lt_q;
  assign a_x = {SX & A[WIDTH-1], A};
  assign b_x = {SX & B[WIDTH-1], B};
  always_comb begin
    local_gt = a_x > b_x;
    local_eq = A == B;
`ifdef CPT4_CASCADE_EN
    cmp_gt = local_eq ? casc_gt : local_gt;
    cmp_eq = local_eq ? casc_eq : 1'b0;
    cmp_lt = local_eq ? casc_lt : !local_gt;
`else
    cmp_gt = local_gt;
    cmp_eq = local_eq;
    cmp_lt = !local_gt && !local_eq;
`endif
    out_valid_d = in_valid;
    gt_d = in_valid ? cmp_gt : gt_q;
    eq_d = in_valid ? cmp_eq : eq_q;
    lt_d = in_valid ? cmp_lt : lt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      gt_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      gt_q <= gt_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign Y = gt_q;
  assign gt = gt_q;
  assign eq = eq_q;
  assign lt = lt_q;
endmodule

// File: tb/tb_cpt4_comparator.sv
// tb_cpt4_comparator: directed self-checking bench for unsigned and signed cpt4_comparator instances
module tb_cpt4_comparator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic casc_gt = 1'b0;
  logic casc_eq = 1'b1;
  logic casc_lt = 1'b0;
  logic u_v, u_y, u_gt, u_eq, u_lt;
  logic s_v, s_y, s_gt, s_eq, s_lt;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  cpt4_comparator #(.WIDTH(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
`ifdef CPT4_CASCADE_EN
    .casc_gt(casc_gt), .casc_eq(casc_eq), .casc_lt(casc_lt),
`endif
    .out_valid(u_v), .Y(u_y), .gt(u_gt), .eq(u_eq), .lt(u_lt)
  );
  cpt4_comparator #(.WIDTH(4), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
`ifdef CPT4_CASCADE_EN
    .casc_gt(casc_gt), .casc_eq(casc_eq), .casc_lt(casc_lt),
`endif
    .out_valid(s_v), .Y(s_y), .gt(s_gt), .eq(s_eq), .lt(s_lt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [3:0] na, input logic [3:0] nb);
    in_valid = v;
    a = na;
    b = nb;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("reset_u", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b00000);
    chk("reset_s", {s_v, s_y, s_gt, s_eq, s_lt}, 5'b00000);
    #11 rst_n = 1'b1;
    step(1, 4'd4, 4'd0);
    chk("gt_4_0", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b11100);
    step(1, 4'd9, 4'd3);
    chk("gt_9_3", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b11100);
    step(1, 4'd3, 4'd9);
    chk("lt_3_9", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b10001);
    step(1, 4'd13, 4'd15);
    chk("lt_13_15", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b10001);
    step(1, 4'd2, 4'd2);
    chk("eq_2_2", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b10010);
    step(1, 4'd15, 4'd15);
    chk("eq_15_15", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b10010);
    step(1, 4'd15, 4'd0);
    chk("gt_max_0", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b11100);
    chk("s_lt_m1_0", {s_v, s_y, s_gt, s_eq, s_lt}, 5'b10001);
    step(1, 4'd0, 4'd0);
    chk("eq_0_0", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b10010);
    step(0, 4'd5, 4'd9);
    chk("hold_idle", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b00010);
    step(1, 4'b1000, 4'b0111);
    chk("s_lt_m8_7", {s_v, s_y, s_gt, s_eq, s_lt}, 5'b10001);
    chk("u_gt_8_7", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b11100);
    step(1, 4'b0111, 4'b1000);
    chk("s_gt_7_m8", {s_v, s_y, s_gt, s_eq, s_lt}, 5'b11100);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_u", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b00000);
    chk("midrst_s", {s_v, s_y, s_gt, s_eq, s_lt}, 5'b00000);
    #1 rst_n = 1'b1;
    step(0, 4'd7, 4'd1);
    chk("post_rst_idle", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b00000);
`ifdef CPT4_CASCADE_EN
    casc_gt = 1'b1;
    casc_eq = 1'b0;
    step(1, 4'd5, 4'd5);
    chk("casc_eq_gt", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b11100);
    step(1, 4'd3, 4'd5);
    chk("casc_local_lt", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b10001);
    casc_gt = 1'b0;
    casc_lt = 1'b1;
    step(1, 4'd6, 4'd5);
    chk("casc_local_gt", {u_v, u_y, u_gt, u_eq, u_lt}, 5'b11100);
    casc_lt = 1'b0;
    casc_eq = 1'b1;
`endif
    for (int j = 0; j < 1000; j++) begin
      logic [3:0] ea, eb;
      ea = 4'((5 * j + 4) % 16);
      eb = 4'((3 * j) % 16);
      step(1, ea, eb);
      chk("sweep_u_y", {u_v, u_y}, {1'b1, ea > eb});
      chk("sweep_onehot", {29'd0, u_gt, u_eq, u_lt},
          (ea > eb) ? 32'd4 : (ea == eb) ? 32'd2 : 32'd1);
      chk("sweep_s_y", {31'd0, s_y}, {31'd0, (ea ^ 4'h8) > (eb ^ 4'h8)});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
